// File: rtl/mips_dbus_responder_pkg.sv
// Shared constants for the data-bus responder: address map, STATUS and TCTRL bit positions.
package dbus_pkg;

  localparam logic [7:0] RAM_TOP  = 8'hEF;
  localparam logic [7:0] A_TXDATA = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF1;
  localparam logic [7:0] A_TIMER  = 8'hF2;
  localparam logic [7:0] A_TCMP   = 8'hF3;
  localparam logic [7:0] A_TCTRL  = 8'hF4;

  localparam int unsigned ST_EMPTY = 0;
  localparam int unsigned ST_FULL  = 1;
  localparam int unsigned ST_TFLAG = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam int unsigned TC_EN      = 0;
  localparam int unsigned TC_AUTOCLR = 1;

  localparam logic [7:0] TCMP_RESET = 8'hFF;

endpackage

// File: rtl/mips_dbus_responder_io_fifo.sv
// Byte FIFO for the output port; a push into a full FIFO is still accepted when a pop frees a slot the same cycle.
module io_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty FIFO presents zero rather than a stale entry.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mips_dbus_responder.sv
// Data-bus responder: 240-byte scratch RAM plus an I/O window with a byte-output FIFO and a compare timer.
module mips_dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memwrite,
  input  logic [7:0] aluout,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       tmr_irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    ram [240];
  logic [7:0]    timer;
  logic [7:0]    tcmp;
  logic          en;
  logic          autoclr;
  logic          ovf;
  logic          tflag;

  logic          wr;
  logic          ram_sel;
  logic          tx_wr;
  logic          st_wr;
  logic          timer_wr;
  logic          tcmp_wr;
  logic          tctrl_wr;
  logic          pop;
  logic          drop;
  logic          match;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign wr       = memwrite && !reset;
  assign ram_sel  = (aluout <= RAM_TOP);
  assign tx_wr    = wr && (aluout == A_TXDATA);
  assign st_wr    = wr && (aluout == A_STATUS);
  assign timer_wr = wr && (aluout == A_TIMER);
  assign tcmp_wr  = wr && (aluout == A_TCMP);
  assign tctrl_wr = wr && (aluout == A_TCTRL);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign drop      = tx_wr && !pop && (fifo_count == CW'(FIFO_DEPTH));
  assign match     = en && !timer_wr && (timer == tcmp);
  assign tmr_irq   = tflag;

  io_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .din   (writedata),
    .pop   (pop),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (wr && ram_sel) ram[aluout] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer   <= '0;
      tcmp    <= TCMP_RESET;
      en      <= 1'b0;
      autoclr <= 1'b0;
      ovf     <= 1'b0;
      tflag   <= 1'b0;
    end else begin
      if (tcmp_wr) tcmp <= writedata;
      if (tctrl_wr) begin
        en      <= writedata[TC_EN];
        autoclr <= writedata[TC_AUTOCLR];
      end
      if (timer_wr)
        timer <= writedata;
      else if (match)
        timer <= autoclr ? '0 : timer + 1'b1;
      else if (en)
        timer <= timer + 1'b1;
      // Set events take precedence over a same-cycle write-1-to-clear.
      tflag <= match || (tflag && !(st_wr && writedata[ST_TFLAG]));
      ovf   <= drop  || (ovf   && !(st_wr && writedata[ST_OVF]));
    end
  end

  always_comb begin
    readdata = '0;
    if (ram_sel) begin
      readdata = ram[aluout];
    end else begin
      case (aluout)
        A_STATUS: begin
          readdata[ST_EMPTY] = fifo_empty;
          readdata[ST_FULL]  = fifo_full;
          readdata[ST_TFLAG] = tflag;
          readdata[ST_OVF]   = ovf;
        end
        A_TIMER: readdata = timer;
        A_TCMP:  readdata = tcmp;
        A_TCTRL: begin
          readdata[TC_EN]      = en;
          readdata[TC_AUTOCLR] = autoclr;
        end
        default: readdata = '0;
      endcase
    end
  end

endmodule
